// File: rtl/pl_idex_stage.sv
// -----------------------------------------------------------------------------
// pl_idex_stage
//   ID/EX pipeline register of the 8-bit RISC RNS processor.
//
//   Each cycle the decoded ID instruction, its forwarded operands and its
//   control bits are captured into the EX register. The stage also:
//     - detects a load-use hazard against the load sitting in EX, inserts one
//       bubble and stalls IF/ID for that cycle;
//     - squashes the EX register when a branch resolves taken in EX (the ID
//       instruction is on the wrong path, so IF/ID is not stalled);
//     - freezes completely while a multi-cycle EX unit asserts ex_hold.
//   Priority on every edge: reset, flush, hold, bubble, normal capture.
//
// Ports
//   clk, reset              clock and synchronous active-high reset
//   id_*                    decoded instruction, addresses, control, operands
//   branch_taken_EX         branch resolved taken in EX (flush request)
//   ex_hold                 EX busy, freeze this stage
//   stall_IF                combinational: hold PC and IF/ID this cycle
//   ex_*, load_true_EX      registered copies of the ID fields
//   bubble_count            saturating count of load-use bubbles
//   flush_count             saturating count of flushes
// -----------------------------------------------------------------------------
module pl_idex_stage #(
    parameter int PROG_CTR_WID = 10,
    parameter int NUM_DOMAINS  = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      id_valid,
    input  logic [15:0]               id_instr,
    input  logic [PROG_CTR_WID-1:0]   id_pc,
    input  logic [2:0]                id_op1_addr,
    input  logic [2:0]                id_op2_addr,
    input  logic                      id_uses_op1,
    input  logic                      id_uses_op2,
    input  logic [2:0]                id_dst_addr,
    input  logic                      id_reg_wr_en,
    input  logic                      id_mem_rd,
    input  logic                      id_mem_wr,
    input  logic [3:0]                id_alu_op,
    input  logic [NUM_DOMAINS*8-1:0]  id_op1_data,
    input  logic [NUM_DOMAINS*8-1:0]  id_op2_data,
    input  logic                      branch_taken_EX,
    input  logic                      ex_hold,
    output logic                      stall_IF,
    output logic                      ex_valid,
    output logic [15:0]               ex_instr,
    output logic [PROG_CTR_WID-1:0]   ex_pc,
    output logic [2:0]                ex_op1_addr,
    output logic [2:0]                ex_op2_addr,
    output logic [2:0]                ex_dst_addr,
    output logic                      ex_reg_wr_en,
    output logic                      load_true_EX,
    output logic                      ex_mem_wr,
    output logic [3:0]                ex_alu_op,
    output logic [NUM_DOMAINS*8-1:0]  ex_op1_data,
    output logic [NUM_DOMAINS*8-1:0]  ex_op2_data,
    output logic [7:0]                bubble_count,
    output logic [7:0]                flush_count
);

    localparam int DATA_WID = NUM_DOMAINS * 8;

    // Stage state: BUBBLE and FLUSH each last one cycle.
    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_BUBBLE = 2'd1;
    localparam logic [1:0] ST_FLUSH  = 2'd2;

    // Action selected for the coming edge, already priority-resolved.
    localparam logic [2:0] ACT_RESET   = 3'd0;
    localparam logic [2:0] ACT_FLUSH   = 3'd1;
    localparam logic [2:0] ACT_HOLD    = 3'd2;
    localparam logic [2:0] ACT_BUBBLE  = 3'd3;
    localparam logic [2:0] ACT_CAPTURE = 3'd4;

    // Saturating 8-bit increment; the counters must never wrap.
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        logic [7:0] result;
        if (value == 8'hFF) begin
            result = value;
        end else begin
            result = value + 8'd1;
        end
        return result;
    endfunction

    logic [1:0]                state_r;
    logic [1:0]                state_nxt_s;
    logic [2:0]                act_s;
    logic                      hz_s;
    logic                      op1_match_s;
    logic                      op2_match_s;

    logic                      ex_valid_r;
    logic [15:0]               ex_instr_r;
    logic [PROG_CTR_WID-1:0]   ex_pc_r;
    logic [2:0]                ex_op1_addr_r;
    logic [2:0]                ex_op2_addr_r;
    logic [2:0]                ex_dst_addr_r;
    logic                      ex_reg_wr_en_r;
    logic                      load_true_r;
    logic                      ex_mem_wr_r;
    logic [3:0]                ex_alu_op_r;
    logic [DATA_WID-1:0]       ex_op1_data_r;
    logic [DATA_WID-1:0]       ex_op2_data_r;
    logic [7:0]                bubble_count_r;
    logic [7:0]                flush_count_r;
    logic                      stall_s;

    // Load-use hazard detection against the load currently held in EX.
    always_comb begin
        op1_match_s = id_uses_op1 & (id_op1_addr == ex_dst_addr_r);
        op2_match_s = id_uses_op2 & (id_op2_addr == ex_dst_addr_r);
        hz_s        = id_valid & ex_valid_r & load_true_r & ex_reg_wr_en_r
                    & (op1_match_s | op2_match_s);
    end

    // Priority resolution of the per-edge action.
    always_comb begin
        act_s = ACT_CAPTURE;
        if (reset) begin
            act_s = ACT_RESET;
        end else if (branch_taken_EX) begin
            act_s = ACT_FLUSH;
        end else if (ex_hold) begin
            act_s = ACT_HOLD;
        end else if (hz_s) begin
            act_s = ACT_BUBBLE;
        end else begin
            act_s = ACT_CAPTURE;
        end
    end

    // Upstream stall: a flush never stalls because the ID instruction is dead.
    always_comb begin
        if (reset) begin
            stall_s = 1'b0;
        end else begin
            stall_s = (hz_s | ex_hold) & ~branch_taken_EX;
        end
    end

    // Next-state decode; hold leaves the state where it is.
    always_comb begin
        state_nxt_s = state_r;
        case (act_s)
            ACT_RESET:   state_nxt_s = ST_RUN;
            ACT_FLUSH:   state_nxt_s = ST_FLUSH;
            ACT_HOLD:    state_nxt_s = state_r;
            ACT_BUBBLE:  state_nxt_s = ST_BUBBLE;
            ACT_CAPTURE: state_nxt_s = ST_RUN;
            default:     state_nxt_s = ST_RUN;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        state_r <= state_nxt_s;
    end

    // EX valid and control bits; these are the only fields a bubble or flush clears.
    always_ff @(posedge clk) begin
        case (act_s)
            ACT_RESET, ACT_FLUSH, ACT_BUBBLE: begin
                ex_valid_r     <= 1'b0;
                ex_reg_wr_en_r <= 1'b0;
                load_true_r    <= 1'b0;
                ex_mem_wr_r    <= 1'b0;
            end
            ACT_HOLD: begin
                ex_valid_r     <= ex_valid_r;
                ex_reg_wr_en_r <= ex_reg_wr_en_r;
                load_true_r    <= load_true_r;
                ex_mem_wr_r    <= ex_mem_wr_r;
            end
            ACT_CAPTURE: begin
                // A non-valid ID slot must not carry live side effects into EX.
                ex_valid_r     <= id_valid;
                ex_reg_wr_en_r <= id_valid & id_reg_wr_en;
                load_true_r    <= id_valid & id_mem_rd;
                ex_mem_wr_r    <= id_valid & id_mem_wr;
            end
            default: begin
                ex_valid_r     <= 1'b0;
                ex_reg_wr_en_r <= 1'b0;
                load_true_r    <= 1'b0;
                ex_mem_wr_r    <= 1'b0;
            end
        endcase
    end

    // EX data and address fields; only reset and a normal capture change them.
    always_ff @(posedge clk) begin
        case (act_s)
            ACT_RESET: begin
                ex_instr_r    <= 16'h0000;
                ex_pc_r       <= {PROG_CTR_WID{1'b0}};
                ex_op1_addr_r <= 3'd0;
                ex_op2_addr_r <= 3'd0;
                ex_dst_addr_r <= 3'd0;
                ex_alu_op_r   <= 4'd0;
                ex_op1_data_r <= {DATA_WID{1'b0}};
                ex_op2_data_r <= {DATA_WID{1'b0}};
            end
            ACT_CAPTURE: begin
                ex_instr_r    <= id_instr;
                ex_pc_r       <= id_pc;
                ex_op1_addr_r <= id_op1_addr;
                ex_op2_addr_r <= id_op2_addr;
                ex_dst_addr_r <= id_dst_addr;
                ex_alu_op_r   <= id_alu_op;
                ex_op1_data_r <= id_op1_data;
                ex_op2_data_r <= id_op2_data;
            end
            default: begin
                ex_instr_r    <= ex_instr_r;
                ex_pc_r       <= ex_pc_r;
                ex_op1_addr_r <= ex_op1_addr_r;
                ex_op2_addr_r <= ex_op2_addr_r;
                ex_dst_addr_r <= ex_dst_addr_r;
                ex_alu_op_r   <= ex_alu_op_r;
                ex_op1_data_r <= ex_op1_data_r;
                ex_op2_data_r <= ex_op2_data_r;
            end
        endcase
    end

    // Saturating bubble and flush counters, cleared only by reset.
    always_ff @(posedge clk) begin
        case (act_s)
            ACT_RESET: begin
                bubble_count_r <= 8'd0;
                flush_count_r  <= 8'd0;
            end
            ACT_FLUSH: begin
                bubble_count_r <= bubble_count_r;
                flush_count_r  <= sat_inc(flush_count_r);
            end
            ACT_BUBBLE: begin
                bubble_count_r <= sat_inc(bubble_count_r);
                flush_count_r  <= flush_count_r;
            end
            default: begin
                bubble_count_r <= bubble_count_r;
                flush_count_r  <= flush_count_r;
            end
        endcase
    end

    assign stall_IF     = stall_s;
    assign ex_valid     = ex_valid_r;
    assign ex_instr     = ex_instr_r;
    assign ex_pc        = ex_pc_r;
    assign ex_op1_addr  = ex_op1_addr_r;
    assign ex_op2_addr  = ex_op2_addr_r;
    assign ex_dst_addr  = ex_dst_addr_r;
    assign ex_reg_wr_en = ex_reg_wr_en_r;
    assign load_true_EX = load_true_r;
    assign ex_mem_wr    = ex_mem_wr_r;
    assign ex_alu_op    = ex_alu_op_r;
    assign ex_op1_data  = ex_op1_data_r;
    assign ex_op2_data  = ex_op2_data_r;
    assign bubble_count = bubble_count_r;
    assign flush_count  = flush_count_r;

endmodule

// File: tb/tb_pl_idex_stage.sv
// -----------------------------------------------------------------------------
// tb_pl_idex_stage
//   Directed scoreboard bench for pl_idex_stage. The driver applies one input
//   vector per cycle and queues the hand-computed expectation: stall_IF for
//   that cycle and the EX register contents after the following edge. A
//   separate monitor pops each expectation and compares.
// -----------------------------------------------------------------------------
module tb_pl_idex_stage;

    typedef struct packed {
        logic        v;
        logic [15:0] instr;
        logic [9:0]  pc;
        logic [2:0]  a1;
        logic [2:0]  a2;
        logic        u1;
        logic        u2;
        logic [2:0]  dst;
        logic        wr;
        logic        mr;
        logic        mw;
        logic [3:0]  alu;
        logic [7:0]  d1;
        logic [7:0]  d2;
        logic        br;
        logic        hold;
        logic        rst;
    } in_t;

    typedef struct packed {
        logic        valid;
        logic [15:0] instr;
        logic [9:0]  pc;
        logic [2:0]  a1;
        logic [2:0]  a2;
        logic [2:0]  dst;
        logic        wr;
        logic        ld;
        logic        mw;
        logic [3:0]  alu;
        logic [7:0]  d1;
        logic [7:0]  d2;
        logic [7:0]  bc;
        logic [7:0]  fc;
    } regs_t;

    typedef struct packed {
        logic  stall;
        regs_t r;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [9:0]  id_pc;
    logic [2:0]  id_op1_addr;
    logic [2:0]  id_op2_addr;
    logic        id_uses_op1;
    logic        id_uses_op2;
    logic [2:0]  id_dst_addr;
    logic        id_reg_wr_en;
    logic        id_mem_rd;
    logic        id_mem_wr;
    logic [3:0]  id_alu_op;
    logic [7:0]  id_op1_data;
    logic [7:0]  id_op2_data;
    logic        branch_taken_EX;
    logic        ex_hold;
    logic        stall_IF;
    logic        ex_valid;
    logic [15:0] ex_instr;
    logic [9:0]  ex_pc;
    logic [2:0]  ex_op1_addr;
    logic [2:0]  ex_op2_addr;
    logic [2:0]  ex_dst_addr;
    logic        ex_reg_wr_en;
    logic        load_true_EX;
    logic        ex_mem_wr;
    logic [3:0]  ex_alu_op;
    logic [7:0]  ex_op1_data;
    logic [7:0]  ex_op2_data;
    logic [7:0]  bubble_count;
    logic [7:0]  flush_count;

    int    checks   = 0;
    int    failures = 0;
    exp_t  exp_q[$];
    string name_q[$];
    logic  busy = 1'b0;

    pl_idex_stage #(.PROG_CTR_WID(10), .NUM_DOMAINS(1)) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr),
        .id_pc(id_pc), .id_op1_addr(id_op1_addr), .id_op2_addr(id_op2_addr),
        .id_uses_op1(id_uses_op1), .id_uses_op2(id_uses_op2),
        .id_dst_addr(id_dst_addr), .id_reg_wr_en(id_reg_wr_en),
        .id_mem_rd(id_mem_rd), .id_mem_wr(id_mem_wr), .id_alu_op(id_alu_op),
        .id_op1_data(id_op1_data), .id_op2_data(id_op2_data),
        .branch_taken_EX(branch_taken_EX), .ex_hold(ex_hold),
        .stall_IF(stall_IF), .ex_valid(ex_valid), .ex_instr(ex_instr),
        .ex_pc(ex_pc), .ex_op1_addr(ex_op1_addr), .ex_op2_addr(ex_op2_addr),
        .ex_dst_addr(ex_dst_addr), .ex_reg_wr_en(ex_reg_wr_en),
        .load_true_EX(load_true_EX), .ex_mem_wr(ex_mem_wr),
        .ex_alu_op(ex_alu_op), .ex_op1_data(ex_op1_data),
        .ex_op2_data(ex_op2_data), .bubble_count(bubble_count),
        .flush_count(flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t mk_in(
        input logic v, input logic [15:0] instr, input logic [9:0] pc,
        input logic [2:0] a1, input logic [2:0] a2, input logic u1, input logic u2,
        input logic [2:0] dst, input logic wr, input logic mr, input logic mw,
        input logic [3:0] alu, input logic [7:0] d1, input logic [7:0] d2,
        input logic br, input logic hold, input logic rst);
        in_t i;
        i = '{v, instr, pc, a1, a2, u1, u2, dst, wr, mr, mw, alu, d1, d2, br, hold, rst};
        return i;
    endfunction

    function automatic exp_t mk_ex(
        input logic stall, input logic valid, input logic [15:0] instr,
        input logic [9:0] pc, input logic [2:0] a1, input logic [2:0] a2,
        input logic [2:0] dst, input logic wr, input logic ld, input logic mw,
        input logic [3:0] alu, input logic [7:0] d1, input logic [7:0] d2,
        input logic [7:0] bc, input logic [7:0] fc);
        exp_t e;
        e.stall = stall;
        e.r = '{valid, instr, pc, a1, a2, dst, wr, ld, mw, alu, d1, d2, bc, fc};
        return e;
    endfunction

    task automatic issue(input in_t i, input exp_t e, input string nm);
        @(posedge clk);
        #1;
        reset           = i.rst;
        id_valid        = i.v;
        id_instr        = i.instr;
        id_pc           = i.pc;
        id_op1_addr     = i.a1;
        id_op2_addr     = i.a2;
        id_uses_op1     = i.u1;
        id_uses_op2     = i.u2;
        id_dst_addr     = i.dst;
        id_reg_wr_en    = i.wr;
        id_mem_rd       = i.mr;
        id_mem_wr       = i.mw;
        id_alu_op       = i.alu;
        id_op1_data     = i.d1;
        id_op2_data     = i.d2;
        branch_taken_EX = i.br;
        ex_hold         = i.hold;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Monitor: stall_IF checked mid-cycle, EX registers checked after the edge.
    initial begin
        exp_t  cur;
        string nm;
        regs_t act;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                busy = 1'b1;
                cur  = exp_q.pop_front();
                nm   = name_q.pop_front();
                checks++;
                if (stall_IF !== cur.stall) begin
                    failures++;
                    $display("FAIL %s stall_IF actual=%b required=%b", nm, stall_IF, cur.stall);
                end
                @(posedge clk);
                #1;
                act = '{ex_valid, ex_instr, ex_pc, ex_op1_addr, ex_op2_addr, ex_dst_addr,
                        ex_reg_wr_en, load_true_EX, ex_mem_wr, ex_alu_op,
                        ex_op1_data, ex_op2_data, bubble_count, flush_count};
                checks++;
                if (act !== cur.r) begin
                    failures++;
                    $display("FAIL %s ex_regs actual=%h required=%h", nm, act, cur.r);
                end
                busy = 1'b0;
            end
        end
    end

    initial begin
        int bc_exp;
        reset = 1'b1; id_valid = 1'b0; id_instr = 16'h0000; id_pc = 10'd0;
        id_op1_addr = 3'd0; id_op2_addr = 3'd0; id_uses_op1 = 1'b0; id_uses_op2 = 1'b0;
        id_dst_addr = 3'd0; id_reg_wr_en = 1'b0; id_mem_rd = 1'b0; id_mem_wr = 1'b0;
        id_alu_op = 4'd0; id_op1_data = 8'h00; id_op2_data = 8'h00;
        branch_taken_EX = 1'b0; ex_hold = 1'b0;

        // Reset for two cycles, then an idle cycle.
        for (int k = 0; k < 2; k++) begin
            issue(mk_in(1'b0, 16'h0000, 10'd0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1),
                  mk_ex(1'b0, 1'b0, 16'h0000, 10'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 8'd0, 8'd0), "reset");
        end
        issue(mk_in(1'b0, 16'h0000, 10'd0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0),
              mk_ex(1'b0, 1'b0, 16'h0000, 10'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 8'd0, 8'd0), "idle");

        // ADD passes straight through.
        issue(mk_in(1'b1, 16'h1234, 10'd5, 3'd1, 3'd4, 1'b1, 1'b1, 3'd3, 1'b1, 1'b0, 1'b0, 4'h1, 8'h12, 8'h34, 1'b0, 1'b0, 1'b0),
              mk_ex(1'b0, 1'b1, 16'h1234, 10'd5, 3'd1, 3'd4, 3'd3, 1'b1, 1'b0, 1'b0, 4'h1, 8'h12, 8'h34, 8'd0, 8'd0), "add");
        // LOAD r2 follows a non-load; no stall.
        issue(mk_in(1'b1, 16'h8200, 10'd6, 3'd5, 3'd0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, 1'b0, 4'h0, 8'h40, 8'h00, 1'b0, 1'b0, 1'b0),
              mk_ex(1'b0, 1'b1, 16'h8200, 10'd6, 3'd5, 3'd0, 3'd2, 1'b1, 1'b1, 1'b0, 4'h0, 8'h40, 8'h00, 8'd0, 8'd0), "load");
        // User of r2: bubble, EX fields other than control keep the load.
        issue(mk_in(1'b1, 16'h1520, 10'd7, 3'd2, 3'd6, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 4'h2, 8'h55, 8'h66, 1'b0, 1'b0, 1'b0),
              mk_ex(1'b1, 1'b0, 16'h8200, 10'd6, 3'd5, 3'd0, 3'd2, 1'b0, 1'b0, 1'b0, 4'h0, 8'h40, 8'h00, 8'd1, 8'd0), "bubble");
        // Same instruction re-presented with forwarded data; enters EX.
        issue(mk_in(1'b1, 16'h1520, 10'd7, 3'd2, 3'd6, 1'b1, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 4'h2, 8'h77, 8'h66, 1'b0, 1'b0, 1'b0),
              mk_ex(1'b0, 1'b1, 16'h1520, 10'd7, 3'd2, 3'd6, 3'd4, 1'b1, 1'b0, 1'b0, 4'h2, 8'h77, 8'h66, 8'd1, 8'd0), "after_bubble");
        // LOAD r5.
        issue(mk_in(1'b1, 16'h8300, 10'd8, 3'd0, 3'd0, 1'b0, 1'b0, 3'd5, 1'b1, 1'b1, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0),
              mk_ex(1'b0, 1'b1, 16'h8300, 10'd8, 3'd0, 3'd0, 3'd5, 1'b1, 1'b1, 1'b0, 4'h0, 8'h00, 8'h00, 8'd1, 8'd0), "load2");
        // op2 address matches r5 but op2 is unused: no stall.
        issue(mk_in(1'b1, 16'h2005, 10'd9, 3'd1, 3'd5, 1'b1, 1'b0, 3'd6, 1'b1, 1'b0, 1'b0, 4'h3, 8'h11, 8'h22, 1'b0, 1'b0, 1'b0),
              mk_ex(1'b0, 1'b1, 16'h2005, 10'd9, 3'd1, 3'd5, 3'd6, 1'b1, 1'b0, 1'b0, 4'h3, 8'h11, 8'h22, 8'd1, 8'd0), "unused_op2");
        // Both operands match r6 but EX is not a load: no stall. This one is a load of r1.
        issue(mk_in(1'b1, 16'h3600, 10'd10, 3'd6, 3'd6, 1'b1, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0, 4'h5, 8'h33, 8'h44, 1'b0, 1'b0, 1'b0),
              mk_ex(1'b0, 1'b1, 16'h3600, 10'd10, 3'd6, 3'd6, 3'd1, 1'b1, 1'b1, 1'b0, 4'h5, 8'h33, 8'h44, 8'd1, 8'd0), "nonload_match");
        // Hazard on r1 and a taken branch together: flush wins.
        issue(mk_in(1'b1, 16'h4100, 10'd11, 3'd1, 3'd0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b0, 1'b0, 4'h6, 8'h99, 8'h88, 1'b1, 1'b0, 1'b0),
              mk_ex(1'b0, 1'b0, 16'h3600, 10'd10, 3'd6, 3'd6, 3'd1, 1'b0, 1'b0, 1'b0, 4'h5, 8'h33, 8'h44, 8'd1, 8'd1), "flush_vs_hz");
        // Invalid slot with all control bits set: control captured as 0.
        issue(mk_in(1'b0, 16'h5000, 10'd12, 3'd3, 3'd4, 1'b1, 1'b1, 3'd7, 1'b1, 1'b1, 1'b1, 4'h7, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0),
              mk_ex(1'b0, 1'b0, 16'h5000, 10'd12, 3'd3, 3'd4, 3'd7, 1'b0, 1'b0, 1'b0, 4'h7, 8'h01, 8'h02, 8'd1, 8'd1), "invalid_ctrl");
        // Store.
        issue(mk_in(1'b1, 16'h6000, 10'd13, 3'd1, 3'd2, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b1, 4'h8, 8'hAA, 8'hBB, 1'b0, 1'b0, 1'b0),
              mk_ex(1'b0, 1'b1, 16'h6000, 10'd13, 3'd1, 3'd2, 3'd0, 1'b0, 1'b0, 1'b1, 4'h8, 8'hAA, 8'hBB, 8'd1, 8'd1), "store");
        // Hold for three cycles with changing ID fields: EX frozen, stall high.
        for (int k = 0; k < 3; k++) begin
            issue(mk_in(1'b1, 16'h7000 + 16'(k), 10'd14 + 10'(k), 3'(k), 3'(k + 1), 1'b1, 1'b1, 3'(k + 2), 1'b1, 1'b1, 1'b0, 4'(k + 9), 8'(k), 8'(k + 3), 1'b0, 1'b1, 1'b0),
                  mk_ex(1'b1, 1'b1, 16'h6000, 10'd13, 3'd1, 3'd2, 3'd0, 1'b0, 1'b0, 1'b1, 4'h8, 8'hAA, 8'hBB, 8'd1, 8'd1), "hold");
        end
        // Hold and branch together: flush wins.
        issue(mk_in(1'b1, 16'h7100, 10'd17, 3'd0, 3'd0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b0, 1'b0, 4'h1, 8'h10, 8'h20, 1'b1, 1'b1, 1'b0),
              mk_ex(1'b0, 1'b0, 16'h6000, 10'd13, 3'd1, 3'd2, 3'd0, 1'b0, 1'b0, 1'b0, 4'h8, 8'hAA, 8'hBB, 8'd1, 8'd2), "hold_and_flush");
        // Reset straight out of FLUSH, with hold asserted: stall stays low.
        issue(mk_in(1'b1, 16'h7200, 10'd18, 3'd0, 3'd0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 4'h1, 8'h10, 8'h20, 1'b0, 1'b1, 1'b1),
              mk_ex(1'b0, 1'b0, 16'h0000, 10'd0, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 8'd0, 8'd0), "reset_in_flush");

        // 260 load-use pairs: bubble_count must stop at 255.
        bc_exp = 0;
        for (int k = 0; k < 260; k++) begin
            issue(mk_in(1'b1, 16'h8100, 10'd20, 3'd0, 3'd0, 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0),
                  mk_ex(1'b0, 1'b1, 16'h8100, 10'd20, 3'd0, 3'd0, 3'd1, 1'b1, 1'b1, 1'b0, 4'h0, 8'h00, 8'h00, 8'(bc_exp), 8'd0), "sat_load");
            if (bc_exp < 255) bc_exp = bc_exp + 1;
            issue(mk_in(1'b1, 16'h1100, 10'd21, 3'd1, 3'd0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b0, 1'b0, 4'h2, 8'h05, 8'h06, 1'b0, 1'b0, 1'b0),
                  mk_ex(1'b1, 1'b0, 16'h8100, 10'd20, 3'd0, 3'd0, 3'd1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 8'(bc_exp), 8'd0), "sat_bubble");
        end

        // Drain the scoreboard with a bounded wait.
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            #2;
            if (exp_q.size() == 0 && !busy) break;
        end
        if (exp_q.size() != 0 || busy) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
